// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, region decode, SETUP/ACCESS sequencing.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait too long for PREADY.
module apb_master_arbiter #(
    parameter int          ADDR_WIDTH    = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [15:0] P_PSEL0_START = 16'hC000,
    parameter logic [15:0] P_PSEL1_START = 16'hC010,
    parameter logic [15:0] P_PSEL2_START = 16'hC020,
    parameter logic [15:0] P_PSEL3_START = 16'hC030,
    parameter logic [15:0] P_PSEL0_SIZE  = 16'h0010,
    parameter logic [15:0] P_PSEL1_SIZE  = 16'h0010,
    parameter logic [15:0] P_PSEL2_SIZE  = 16'h0010,
    parameter logic [15:0] P_PSEL3_SIZE  = 16'h0010
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic                  write0_i,
    input  logic                  write1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic [3:0]            strb0_i,
    input  logic [3:0]            strb1_i,
    output logic                  done0_o,
    output logic                  done1_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [3:0]            PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA0,
    input  logic [DATA_WIDTH-1:0] PRDATA1,
    input  logic [DATA_WIDTH-1:0] PRDATA2,
    input  logic [DATA_WIDTH-1:0] PRDATA3,
    input  logic                  PREADY0,
    input  logic                  PREADY1,
    input  logic                  PREADY2,
    input  logic                  PREADY3,
    input  logic                  PSLVERR0,
    input  logic                  PSLVERR1,
    input  logic                  PSLVERR2,
    input  logic                  PSLVERR3
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [15:0] REGION_START [4] = '{P_PSEL0_START, P_PSEL1_START, P_PSEL2_START, P_PSEL3_START};
    localparam logic [15:0] REGION_SIZE  [4] = '{P_PSEL0_SIZE, P_PSEL1_SIZE, P_PSEL2_SIZE, P_PSEL3_SIZE};

    state_t                state;
    state_t                state_next;
    logic                  grant;
    logic                  grant_next;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_strb;
    logic [15:0]           region;
    logic [1:0]            dec_idx;
    logic                  dec_hit;
    logic [1:0]            sel_idx;
    logic                  mapped;
    logic [ADDR_WIDTH-1:0] apb_addr;
    logic                  apb_write;
    logic [DATA_WIDTH-1:0] apb_wdata;
    logic [3:0]            apb_strb;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  done0;
    logic                  done1;
    logic                  slave_ready;
    logic                  slave_err;
    logic [DATA_WIDTH-1:0] slave_rdata;
    logic                  finish;

    // Both requesting: favour the one not served last; last_grant resets to 1.
    always_comb begin
        grant_next = req1_i & (~req0_i | ~last_grant);
        req_addr   = grant_next ? addr1_i  : addr0_i;
        req_write  = grant_next ? write1_i : write0_i;
        req_wdata  = grant_next ? wdata1_i : wdata0_i;
        req_strb   = grant_next ? strb1_i  : strb0_i;
    end

    // Reverse scan so the lowest-numbered region wins if ranges overlap.
    always_comb begin
        region  = req_addr[27:12];
        dec_hit = 1'b0;
        dec_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((region >= REGION_START[i]) &&
                ({1'b0, region} < ({1'b0, REGION_START[i]} + {1'b0, REGION_SIZE[i]}))) begin
                dec_hit = 1'b1;
                dec_idx = 2'(i);
            end
        end
    end

    always_comb begin
        case (sel_idx)
            2'd0: begin
                slave_ready = PREADY0;
                slave_err   = PSLVERR0;
                slave_rdata = PRDATA0;
            end
            2'd1: begin
                slave_ready = PREADY1;
                slave_err   = PSLVERR1;
                slave_rdata = PRDATA1;
            end
            2'd2: begin
                slave_ready = PREADY2;
                slave_err   = PSLVERR2;
                slave_rdata = PRDATA2;
            end
            default: begin
                slave_ready = PREADY3;
                slave_err   = PSLVERR3;
                slave_rdata = PRDATA3;
            end
        endcase
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       timeout_hit;

    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign timeout_hit  = (wait_cnt_inc == TIMEOUT_LIMIT);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= 8'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 8'd0;
        end else if ((state == ACCESS) && !slave_ready) begin
            wait_cnt <= wait_cnt_inc;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req0_i || req1_i) state_next = SETUP;
            SETUP:   state_next = mapped ? ACCESS : RESP;
            ACCESS: begin
                if (slave_ready) state_next = RESP;
`ifdef APB_ARB_TIMEOUT_EN
                else if (timeout_hit) state_next = RESP;
`endif
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign finish = (state != RESP) && (state_next == RESP);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_next;
    end

    // Request attributes are captured once in IDLE and held for the whole transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            sel_idx    <= 2'd0;
            mapped     <= 1'b0;
            apb_addr   <= '0;
            apb_write  <= 1'b0;
            apb_wdata  <= '0;
            apb_strb   <= 4'b0;
            rdata      <= '0;
            err        <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
        end else begin
            done0 <= finish & ~grant;
            done1 <= finish & grant;
            case (state)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        grant     <= grant_next;
                        apb_addr  <= req_addr;
                        apb_write <= req_write;
                        apb_wdata <= req_wdata;
                        apb_strb  <= req_write ? req_strb : 4'b0;
                        sel_idx   <= dec_idx;
                        mapped    <= dec_hit;
                    end
                end
                SETUP: begin
                    if (!mapped) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end
                end
                ACCESS: begin
                    if (slave_ready) begin
                        rdata <= apb_write ? '0 : slave_rdata;
                        err   <= slave_err;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
`endif
                end
                RESP:    last_grant <= grant;
                default: ;
            endcase
        end
    end

    assign PSEL    = (((state == SETUP) || (state == ACCESS)) && mapped) ? (4'b0001 << sel_idx) : 4'b0000;
    assign PENABLE = (state == ACCESS);
    assign PADDR   = apb_addr;
    assign PWRITE  = apb_write;
    assign PWDATA  = apb_wdata;
    assign PSTRB   = apb_strb;
    assign rdata_o = rdata;
    assign err_o   = err;
    assign done0_o = done0;
    assign done1_o = done1;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: vector table plus hand-written arbitration,
// reset and (with APB_ARB_TIMEOUT_EN) timeout sequences, all checked through a scoreboard.
module tb_apb_master_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] slv_rdata;
        logic        slv_err;
        logic [3:0]  exp_psel;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  pstrb;
        logic [3:0]  psel;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          cyc;
        int          start;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req0_i, req1_i, write0_i, write1_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [3:0]  strb0_i, strb1_i;
    logic        done0_o, done1_o, err_o, PENABLE, PWRITE;
    logic [31:0] rdata_o, PADDR, PWDATA;
    logic [3:0]  PSEL, PSTRB;

    int          slv_waits [4];
    logic [31:0] slv_rdata [4];
    logic        slv_err   [4];
    logic [3:0]  ready_v;
    logic [3:0]  err_v;
    logic [31:0] rdata_v   [4];
    int          acc_cnt = 0;

    exp_t        sb [$];
    exp_t        mon_e;
    vec_t        vecs [9];
    int          cycle = 0;
    int          done_count = 0;
    int          setup_seen = 0;
    int          acc_seen = 0;
    int          check_count = 0;
    int          pass_count = 0;

    apb_master_arbiter dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req0_i   (req0_i),
        .req1_i   (req1_i),
        .addr0_i  (addr0_i),
        .addr1_i  (addr1_i),
        .write0_i (write0_i),
        .write1_i (write1_i),
        .wdata0_i (wdata0_i),
        .wdata1_i (wdata1_i),
        .strb0_i  (strb0_i),
        .strb1_i  (strb1_i),
        .done0_o  (done0_o),
        .done1_o  (done1_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PRDATA0  (rdata_v[0]),
        .PRDATA1  (rdata_v[1]),
        .PRDATA2  (rdata_v[2]),
        .PRDATA3  (rdata_v[3]),
        .PREADY0  (ready_v[0]),
        .PREADY1  (ready_v[1]),
        .PREADY2  (ready_v[2]),
        .PREADY3  (ready_v[3]),
        .PSLVERR0 (err_v[0]),
        .PSLVERR1 (err_v[1]),
        .PSLVERR2 (err_v[2]),
        .PSLVERR3 (err_v[3])
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cycle++;

    // Slave model: unselected slaves show ready=1, error=1 and junk data so a bad mux is visible.
    always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            ready_v[n] = PSEL[n] ? (PENABLE && (acc_cnt >= slv_waits[n])) : 1'b1;
            err_v[n]   = PSEL[n] ? slv_err[n] : 1'b1;
            rdata_v[n] = PSEL[n] ? slv_rdata[n] : (32'hBAD0_0000 | 32'(n));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic exp_t makeExp(input vec_t v, input int start, input int cyc);
        exp_t e;
        e.port  = v.port;
        e.addr  = v.addr;
        e.write = v.write;
        e.wdata = v.wdata;
        e.pstrb = v.write ? v.strb : 4'b0;
        e.psel  = v.exp_psel;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.acc   = (v.exp_psel != 4'b0) ? v.waits + 1 : 0;
        e.cyc   = cyc;
        e.start = start;
        return e;
    endfunction

    task automatic loadSlave(input vec_t v);
        for (int n = 0; n < 4; n++) begin
            if (v.exp_psel[n]) begin
                slv_waits[n] = v.waits;
                slv_rdata[n] = v.slv_rdata;
                slv_err[n]   = v.slv_err;
            end
        end
    endtask

    task automatic driveReq(input vec_t v);
        if (v.port) begin
            req1_i = 1'b1; addr1_i = v.addr; write1_i = v.write; wdata1_i = v.wdata; strb1_i = v.strb;
        end else begin
            req0_i = 1'b1; addr0_i = v.addr; write0_i = v.write; wdata0_i = v.wdata; strb0_i = v.strb;
        end
    endtask

    task automatic waitDones(input int target, input int limit);
        int base = done_count;
        int c = 0;
        while ((done_count - base < target) && (c < limit)) begin
            @(negedge PCLK);
            #1;
            c++;
        end
        if (done_count - base < target) checkOutput("done_wait", done_count - base, target);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge PCLK);
        #1;
        loadSlave(v);
        driveReq(v);
        sb.push_back(makeExp(v, cycle + 1, (v.exp_psel != 4'b0) ? 3 + v.waits : 2));
        waitDones(1, 60);
        req0_i = 1'b0;
        req1_i = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge PCLK);
        #1;
        PRESETn = 1'b0;
        req0_i  = 1'b0;
        req1_i  = 1'b0;
        @(negedge PCLK);
        #1;
        PRESETn = 1'b1;
    endtask

    // Scoreboard consumer: APB phase checks while a transfer is pending, result checks on done.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            setup_seen = 0;
            acc_seen   = 0;
        end else begin
            if ((PSEL != 4'b0) && (sb.size() > 0)) begin
                checkOutput("psel", PSEL, sb[0].psel);
                checkOutput("paddr", PADDR, sb[0].addr);
                checkOutput("pwrite", PWRITE, sb[0].write);
                checkOutput("pstrb", PSTRB, sb[0].pstrb);
                if (sb[0].write) checkOutput("pwdata", PWDATA, sb[0].wdata);
                if (PENABLE) acc_seen++;
                else setup_seen++;
            end
            if (PENABLE) checkOutput("penable_has_psel", PSEL != 4'b0, 1);
            if (done0_o || done1_o) begin
                done_count++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", {done1_o, done0_o}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("done_port", {done1_o, done0_o}, mon_e.port ? 2'b10 : 2'b01);
                    checkOutput("rdata", rdata_o, mon_e.rdata);
                    checkOutput("err", err_o, mon_e.err);
                    checkOutput("setup_cycles", setup_seen, (mon_e.psel != 4'b0) ? 1 : 0);
                    checkOutput("access_cycles", acc_seen, mon_e.acc);
                    checkOutput("done_cycle", cycle - mon_e.start + 1, mon_e.cyc);
                end
                setup_seen = 0;
                acc_seen   = 0;
            end
        end
    end

    initial begin
        vec_t a0;
        vec_t a1;
        int   start;
        int   base;
        logic seen;

        vecs[0] = '{1'b0, 32'h0C030010, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'hFFFF0000, 1'b0, 4'b1000, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0C000004, 1'b0, 32'h11110000, 4'hF, 2, 32'h000000A5, 1'b0, 4'b0001, 32'h000000A5, 1'b0};
        vecs[2] = '{1'b0, 32'h0C040000, 1'b1, 32'h22220000, 4'hF, 0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 32'h0C020008, 1'b1, 32'h12345678, 4'h3, 0, 32'hFFFF0002, 1'b1, 4'b0100, 32'h0, 1'b1};
        vecs[4] = '{1'b1, 32'h0C01FFFC, 1'b0, 32'h0, 4'h0, 1, 32'h5A5A0001, 1'b0, 4'b0010, 32'h5A5A0001, 1'b0};
        vecs[5] = '{1'b1, 32'h0C00FFFF, 1'b0, 32'h0, 4'h6, 0, 32'h11223344, 1'b0, 4'b0001, 32'h11223344, 1'b0};
        vecs[6] = '{1'b0, 32'h0BFFF000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1};
        vecs[7] = '{1'b0, 32'h0C03F000, 1'b0, 32'h0, 4'hF, 1, 32'hCAFEF00D, 1'b1, 4'b1000, 32'hCAFEF00D, 1'b1};
        vecs[8] = '{1'b1, 32'hFC030010, 1'b0, 32'h0, 4'hC, 3, 32'h0000BEEF, 1'b0, 4'b1000, 32'h0000BEEF, 1'b0};

        slv_waits = '{0, 0, 0, 0};
        slv_rdata = '{32'h0, 32'h0, 32'h0, 32'h0};
        slv_err   = '{1'b0, 1'b0, 1'b0, 1'b0};
        PRESETn = 1'b0;
        req0_i = 1'b0; req1_i = 1'b0; write0_i = 1'b0; write1_i = 1'b0;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0; strb0_i = '0; strb1_i = '0;

        repeat (2) @(negedge PCLK);
        #1;
        checkOutput("reset_psel", PSEL, 4'b0);
        checkOutput("reset_penable", PENABLE, 1'b0);
        checkOutput("reset_paddr", PADDR, 32'h0);
        checkOutput("reset_pwrite", PWRITE, 1'b0);
        checkOutput("reset_pwdata", PWDATA, 32'h0);
        checkOutput("reset_pstrb", PSTRB, 4'b0);
        checkOutput("reset_done", {done1_o, done0_o}, 2'b00);
        checkOutput("reset_rdata", rdata_o, 32'h0);
        checkOutput("reset_err", err_o, 1'b0);
        PRESETn = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Both requesters held from reset: grants must alternate 0,1,0,1 at four-cycle spacing.
        resetDut();
        a0 = '{1'b0, 32'h0C020010, 1'b0, 32'h0, 4'hF, 0, 32'h00007777, 1'b0, 4'b0100, 32'h00007777, 1'b0};
        a1 = '{1'b1, 32'h0C010004, 1'b1, 32'h0BADCAFE, 4'h5, 0, 32'hFFFF0001, 1'b0, 4'b0010, 32'h0, 1'b0};
        @(negedge PCLK);
        #1;
        loadSlave(a0);
        loadSlave(a1);
        driveReq(a0);
        driveReq(a1);
        start = cycle + 1;
        sb.push_back(makeExp(a0, start, 3));
        sb.push_back(makeExp(a1, start, 7));
        sb.push_back(makeExp(a0, start, 11));
        sb.push_back(makeExp(a1, start, 15));
        waitDones(4, 40);
        req0_i = 1'b0;
        req1_i = 1'b0;
        checkOutput("alternation_drained", sb.size(), 0);
        sb.delete();

`ifdef APB_ARB_TIMEOUT_EN
        a1 = '{1'b1, 32'h0C010000, 1'b0, 32'h0, 4'h0, 1000, 32'h33334444, 1'b0, 4'b0010, 32'h0, 1'b1};
        @(negedge PCLK);
        #1;
        loadSlave(a1);
        driveReq(a1);
        mon_e = makeExp(a1, cycle + 1, 257);
        mon_e.acc = 255;
        sb.push_back(mon_e);
        waitDones(1, 320);
        req1_i = 1'b0;
        sb.delete();
`endif

        // Reset pulsed while a slave stalls in ACCESS: bus drops at once and no done follows.
        a0 = '{1'b0, 32'h0C030020, 1'b0, 32'h0, 4'hF, 50, 32'h99990000, 1'b0, 4'b1000, 32'h0, 1'b0};
        @(negedge PCLK);
        #1;
        loadSlave(a0);
        driveReq(a0);
        seen = 1'b0;
        for (int c = 0; (c < 10) && !seen; c++) begin
            @(negedge PCLK);
            #1;
            if (PENABLE) seen = 1'b1;
        end
        checkOutput("reached_access", seen, 1'b1);
        repeat (2) @(negedge PCLK);
        base = done_count;
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("async_reset_psel", PSEL, 4'b0);
        checkOutput("async_reset_penable", PENABLE, 1'b0);
        checkOutput("async_reset_paddr", PADDR, 32'h0);
        checkOutput("async_reset_done", {done1_o, done0_o}, 2'b00);
        req0_i = 1'b0;
        @(negedge PCLK);
        #1;
        PRESETn = 1'b1;
        repeat (6) @(negedge PCLK);
        #1;
        checkOutput("no_done_after_reset", done_count, base);
        checkOutput("idle_after_reset_psel", PSEL, 4'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
